// File: rtl/csa_pipe.sv
// Pipelined carry-skip adder with a valid/ready handshake on both sides.
// Optional subtract mode is enabled by defining CSA_PIPE_SUB_EN, which adds the 'sub' input.
module csa_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NB   = WIDTH / BLK;
    localparam int BPS  = (STAGES > 0) ? NB / STAGES : 1;
    localparam int LAST = (STAGES > 0) ? STAGES - 1 : 0;

    if (WIDTH % BLK != 0) begin : g_err_blk
        $error("csa_pipe: WIDTH must be a multiple of BLK");
    end
    if (STAGES < 1) begin : g_err_stages_low
        $error("csa_pipe: STAGES must be at least 1");
    end else if (STAGES > NB || NB % STAGES != 0) begin : g_err_stages_split
        $error("csa_pipe: STAGES must evenly divide the number of skip blocks");
    end

    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] n_sum   [STAGES];
    logic             n_carry [STAGES];
    logic [WIDTH-1:0] b_eff;
    logic             c_first;
    logic             advance;

`ifdef CSA_PIPE_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign c_first = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign c_first = cin;
`endif

    // Each stage ripples through its own slice of skip blocks; a fully propagating
    // block forwards its incoming carry directly instead of the rippled one.
    always_comb begin
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic [WIDTH-1:0] ss;
        logic             c;
        logic             bc;
        logic             prop;
        int               src;
        sa   = '0;
        sb   = '0;
        ss   = '0;
        c    = 1'b0;
        bc   = 1'b0;
        prop = 1'b0;
        src  = 0;
        for (int k = 0; k < STAGES; k++) begin
            src = (k == 0) ? 0 : k - 1;
            sa  = (k == 0) ? a       : r_a[src];
            sb  = (k == 0) ? b_eff   : r_b[src];
            ss  = (k == 0) ? '0      : r_sum[src];
            c   = (k == 0) ? c_first : r_carry[src];
            for (int j = 0; j < BPS; j++) begin
                bc   = c;
                prop = 1'b1;
                for (int i = 0; i < BLK; i++) begin
                    ss[(k * BPS + j) * BLK + i] = sa[(k * BPS + j) * BLK + i]
                                                ^ sb[(k * BPS + j) * BLK + i] ^ c;
                    c = (sa[(k * BPS + j) * BLK + i] & sb[(k * BPS + j) * BLK + i])
                      | (c & (sa[(k * BPS + j) * BLK + i] ^ sb[(k * BPS + j) * BLK + i]));
                    prop = prop & (sa[(k * BPS + j) * BLK + i] ^ sb[(k * BPS + j) * BLK + i]);
                end
                if (prop) begin
                    c = bc;
                end
            end
            n_sum[k]   = ss;
            n_carry[k] = c;
        end
    end

    // Whole pipeline moves together; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
            end
        end else if (advance) begin
            r_valid[0] <= in_valid;
            r_a[0]     <= a;
            r_b[0]     <= b_eff;
            r_sum[0]   <= n_sum[0];
            r_carry[0] <= n_carry[0];
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_a[k]     <= r_a[k-1];
                r_b[k]     <= r_b[k-1];
                r_sum[k]   <= n_sum[k];
                r_carry[k] <= n_carry[k];
            end
        end
    end

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance || !rst_n;
    assign out_valid = r_valid[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_carry[LAST];
    assign ovf       = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1])
                    && (r_sum[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

endmodule

// File: tb/tb_csa_pipe.sv
// Scoreboard bench for csa_pipe: directed tests on the default 32/4/2 build and
// a randomised handshake run on a 16/4/4 build; honours CSA_PIPE_SUB_EN.
module tb_csa_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, sub_v;
    logic [31:0] a, b, sum;

    logic        rst16_n, iv16, ir16, cin16, ov16, or16, cout16, ovf16, sub16;
    logic [15:0] a16, b16, sum16;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    int   n_out    = 0;
    int   base     = 0;
    bit   check_lat = 1'b0;
    bit   done16    = 1'b0;
    bit   acc16     = 1'b0;

    logic [33:0] q32 [$];
    int          qcyc [$];
    logic [33:0] q16 [$];

    csa_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CSA_PIPE_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    csa_pipe #(.WIDTH(16), .BLK(4), .STAGES(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst16_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
`ifdef CSA_PIPE_SUB_EN
        .sub       (sub16),
`endif
        .out_valid (ov16),
        .out_ready (or16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Returns {ovf, cout, sum} for a w-bit add using plain integer arithmetic.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci, input logic s);
        logic [31:0] mask;
        logic [31:0] be;
        logic [31:0] sm;
        logic [32:0] full;
        logic        c0, co, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        be   = (s ? ~bv : bv) & mask;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, av & mask} + {1'b0, be} + {32'd0, c0};
        sm   = full[31:0] & mask;
        co   = full[w];
        ov   = (av[w-1] == be[w-1]) && (sm[w-1] != av[w-1]);
        return {ov, co, sm};
    endfunction

    task automatic waitAccept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
        a        = av;
        b        = bv;
        cin      = cv;
        sub_v    = sv;
        in_valid = 1'b1;
        waitAccept();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        int          ac;
        if (!rst_n) begin
            q32.delete();
            qcyc.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (q32.size() == 0) begin
                    checkOutput("unexpected_out", out_valid, 0);
                end else begin
                    e  = q32.pop_front();
                    ac = qcyc.pop_front();
                    checkOutput("sum", sum, e[31:0]);
                    checkOutput("cout", cout, e[32]);
                    checkOutput("ovf", ovf, e[33]);
                    if (check_lat) checkOutput("latency", cycle - ac, 2);
                end
            end
            if (in_valid && in_ready) begin
                q32.push_back(model(32, a, b, cin, sub_v));
                qcyc.push_back(cycle);
            end
        end
    end

    always @(negedge clk) begin
        logic [33:0] e;
        acc16 = iv16 && ir16 && rst16_n;
        if (rst16_n) begin
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    checkOutput("unexpected16", ov16, 0);
                end else begin
                    e = q16.pop_front();
                    checkOutput("sum16", sum16, e[15:0]);
                    checkOutput("cout16", cout16, e[32]);
                    checkOutput("ovf16", ovf16, e[33]);
                end
            end
            if (acc16) q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
        end
    end

    // Random valid and out_ready patterns; operands are held until accepted.
    initial begin
        rst16_n = 1'b0; iv16 = 1'b0; or16 = 1'b0; cin16 = 1'b0; sub16 = 1'b0;
        a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst16_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!iv16 || acc16) begin
                iv16  = ($urandom_range(0, 3) != 0);
                a16   = 16'($urandom);
                b16   = 16'($urandom);
                cin16 = 1'($urandom);
`ifdef CSA_PIPE_SUB_EN
                sub16 = 1'($urandom);
`endif
            end
            or16 = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("drain16", q16.size(), 0);
        done16 = 1'b1;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub_v = 1'b0;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check_lat = 1'b1;

        applyStimulus(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        idle(4);

        base = n_out;
        for (int i = 0; i < 8; i++) applyStimulus(32'(i), 32'(i * 3), 1'b0, 1'b0);
        idle(4);
        checkOutput("burst_count", n_out - base, 8);

        // Two operands fill the pipe, the third must wait behind the stall.
        check_lat = 1'b0;
        out_ready = 1'b0;
        base      = n_out;
        applyStimulus(32'd100, 32'd200, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        a = 32'd3; b = 32'd4; cin = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_sum", sum, 300);
            checkOutput("stall_cout", cout, 0);
            checkOutput("stall_ovf", ovf, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitAccept();
        idle(4);
        checkOutput("stall_count", n_out - base, 3);

        check_lat = 1'b1;
        base      = n_out;
        applyStimulus(32'd10, 32'd20, 1'b0, 1'b0);
        applyStimulus(32'd30, 32'd40, 1'b0, 1'b0);
        rst_n = 1'b0; out_ready = 1'b0; a = 32'd55; b = 32'd66; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        checkOutput("rst_mid_inflight", out_valid, 1);
        @(posedge clk);
        #1;
        checkOutput("rst_mid_valid", out_valid, 0);
        checkOutput("rst_mid_sum", sum, 0);
        checkOutput("rst_mid_cout", cout, 0);
        checkOutput("rst_mid_ovf", ovf, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        idle(6);
        checkOutput("rst_no_stale", n_out - base, 0);

`ifdef CSA_PIPE_SUB_EN
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
        applyStimulus(32'd9, 32'd4, 1'b0, 1'b1);
        idle(4);
`endif

        for (int n = 0; n < 5000 && !done16; n++) @(posedge clk);
        checkOutput("done16", done16, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
